// File: rtl/can_tx_mailbox_arbiter_pkg.sv
// rtl/can_tx_mailbox_arbiter_pkg.sv - shared CAN frame widths, frame struct and arbiter state enum
package can_pkg;

    localparam int CAN_ID_W   = 11;
    localparam int CAN_DLC_W  = 4;
    localparam int CAN_DATA_W = 64;

    typedef struct packed {
        logic [CAN_ID_W-1:0]   id;
        logic [CAN_DLC_W-1:0]  dlc;
        logic [CAN_DATA_W-1:0] data;
    } can_frame_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LAUNCH,
        ARB_WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/can_tx_mailbox_arbiter_if.sv
// rtl/can_tx_mailbox_arbiter_if.sv - host mailbox and transmitter signal group of the TX arbiter
interface can_tx_mailbox_arbiter_if
    import can_pkg::*;
#(
    parameter int NUM_MB = 4
);
    localparam int MBW = $clog2(NUM_MB);

    logic                  wr_en;
    logic [MBW-1:0]        wr_sel;
    logic [CAN_ID_W-1:0]   wr_id;
    logic [CAN_DLC_W-1:0]  wr_dlc;
    logic [CAN_DATA_W-1:0] wr_data;
    logic                  abort_en;
    logic [MBW-1:0]        abort_sel;
    logic                  wr_err;
    logic [NUM_MB-1:0]     mb_pending;
    logic [NUM_MB-1:0]     mb_done;
    logic [NUM_MB-1:0]     mb_timeout;
    logic                  tx_start;
    logic [CAN_ID_W-1:0]   tx_id;
    logic [CAN_DLC_W-1:0]  tx_dlc;
    logic [CAN_DATA_W-1:0] tx_data;
    logic                  tx_busy;
    logic                  tx_done;

    // Environment side: host plus transmitter
    modport master (
        output wr_en, wr_sel, wr_id, wr_dlc, wr_data, abort_en, abort_sel, tx_busy, tx_done,
        input  wr_err, mb_pending, mb_done, mb_timeout, tx_start, tx_id, tx_dlc, tx_data
    );

    // Arbiter side
    modport slave (
        input  wr_en, wr_sel, wr_id, wr_dlc, wr_data, abort_en, abort_sel, tx_busy, tx_done,
        output wr_err, mb_pending, mb_done, mb_timeout, tx_start, tx_id, tx_dlc, tx_data
    );

endinterface

// File: rtl/can_tx_mailbox_arbiter_prio_select.sv
// rtl/can_tx_mailbox_arbiter_prio_select.sv - picks the pending mailbox with the lowest CAN ID
module can_prio_select
    import can_pkg::*;
#(
    parameter int NUM_MB = 4,
    localparam int MBW = $clog2(NUM_MB)
) (
    input  can_frame_t        frames [NUM_MB],
    input  logic [NUM_MB-1:0] pending,
    output logic              valid,
    output logic [MBW-1:0]    win_idx
);

    logic [CAN_ID_W-1:0] best_id;

    // Strict less-than keeps the lower index on equal IDs
    always_comb begin
        valid   = 1'b0;
        win_idx = '0;
        best_id = '1;
        for (int i = 0; i < NUM_MB; i++) begin
            if (pending[i] && (!valid || frames[i].id < best_id)) begin
                valid   = 1'b1;
                win_idx = MBW'(i);
                best_id = frames[i].id;
            end
        end
    end

endmodule

// File: rtl/can_tx_mailbox_arbiter.sv
// rtl/can_tx_mailbox_arbiter.sv - TX mailbox arbiter for one CAN transmitter; watchdog under CAN_ARB_TIMEOUT_EN
module can_tx_mailbox_arbiter
    import can_pkg::*;
#(
    parameter int NUM_MB      = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input logic                    clk,
    input logic                    rst,
    can_tx_mailbox_arbiter_if.slave bus
);

    localparam int MBW = $clog2(NUM_MB);

    if (NUM_MB < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("can_tx_mailbox_arbiter: NUM_MB must be >= 2 and TIMEOUT_CYC >= 1");
    end

    can_frame_t            mb [NUM_MB];
    logic [NUM_MB-1:0]     pending;
    logic [NUM_MB-1:0]     pending_nxt;
    arb_state_t            state;
    logic [MBW-1:0]        fl_idx;
    logic                  sel_valid;
    logic [MBW-1:0]        sel_idx;
    logic                  in_flight;
    logic                  wr_hit_fl;
    logic                  ab_hit_fl;
    logic                  launch_ok;
    logic                  wd_hit;
    logic                  finish;
    logic                  wr_err;
    logic [NUM_MB-1:0]     mb_done;
    logic                  tx_start;
    logic [CAN_ID_W-1:0]   tx_id;
    logic [CAN_DLC_W-1:0]  tx_dlc;
    logic [CAN_DATA_W-1:0] tx_data;

    can_prio_select #(.NUM_MB(NUM_MB)) u_sel (
        .frames  (mb),
        .pending (pending),
        .valid   (sel_valid),
        .win_idx (sel_idx)
    );

    // The launched mailbox stays locked from LAUNCH until it completes
    assign in_flight = (state != ARB_IDLE);
    assign wr_hit_fl = bus.wr_en    && in_flight && (bus.wr_sel    == fl_idx);
    assign ab_hit_fl = bus.abort_en && in_flight && (bus.abort_sel == fl_idx);

    // A host write/abort touching the winner in the same cycle defers the launch,
    // so the mailbox is never sent with stale contents or after being aborted
    assign launch_ok = (state == ARB_IDLE) && sel_valid && !bus.tx_busy
                     && !(bus.wr_en    && bus.wr_sel    == sel_idx)
                     && !(bus.abort_en && bus.abort_sel == sel_idx);

    assign finish = (state == ARB_WAIT_DONE) && (bus.tx_done || wd_hit);

`ifdef CAN_ARB_TIMEOUT_EN
    logic [31:0]       wd_cnt;
    logic [NUM_MB-1:0] mb_timeout;

    assign wd_hit = (state == ARB_WAIT_DONE) && !bus.tx_done && (wd_cnt == 32'(TIMEOUT_CYC - 1));

    // Watchdog counts WAIT_DONE cycles and pulses the timeout of the stuck mailbox
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt     <= '0;
            mb_timeout <= '0;
        end else begin
            mb_timeout <= '0;
            if (state != ARB_WAIT_DONE) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 32'd1;
            end
            if (wd_hit) begin
                mb_timeout[fl_idx] <= 1'b1;
            end
        end
    end

    assign bus.mb_timeout = mb_timeout;
`else
    assign wd_hit         = 1'b0;
    assign bus.mb_timeout = '0;
`endif

    // Next pending mask: aborts first, then writes (write wins), then completion
    always_comb begin
        pending_nxt = pending;
        for (int i = 0; i < NUM_MB; i++) begin
            if (bus.abort_en && bus.abort_sel == MBW'(i) && !(in_flight && fl_idx == MBW'(i))) begin
                pending_nxt[i] = 1'b0;
            end
        end
        if (bus.wr_en && !wr_hit_fl) begin
            pending_nxt[bus.wr_sel] = 1'b1;
        end
        if (finish) begin
            pending_nxt[fl_idx] = 1'b0;
        end
    end

    // Mailbox storage; the in-flight mailbox is write-protected
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_MB; i++) begin
                mb[i] <= '0;
            end
        end else if (bus.wr_en && !wr_hit_fl) begin
            mb[bus.wr_sel] <= '{id: bus.wr_id, dlc: bus.wr_dlc, data: bus.wr_data};
        end
    end

    // Arbitration FSM with registered transmitter and host status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            fl_idx   <= '0;
            pending  <= '0;
            wr_err   <= 1'b0;
            mb_done  <= '0;
            tx_start <= 1'b0;
            tx_id    <= '0;
            tx_dlc   <= '0;
            tx_data  <= '0;
        end else begin
            pending  <= pending_nxt;
            wr_err   <= wr_hit_fl || ab_hit_fl;
            mb_done  <= '0;
            tx_start <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (launch_ok) begin
                        fl_idx   <= sel_idx;
                        tx_id    <= mb[sel_idx].id;
                        tx_dlc   <= mb[sel_idx].dlc;
                        tx_data  <= mb[sel_idx].data;
                        tx_start <= 1'b1;
                        state    <= ARB_LAUNCH;
                    end
                end
                ARB_LAUNCH: begin
                    state <= ARB_WAIT_DONE;
                end
                ARB_WAIT_DONE: begin
                    if (bus.tx_done) begin
                        mb_done[fl_idx] <= 1'b1;
                        state           <= ARB_IDLE;
                    end else if (wd_hit) begin
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.mb_pending = pending;
    assign bus.wr_err     = wr_err;
    assign bus.mb_done    = mb_done;
    assign bus.tx_start   = tx_start;
    assign bus.tx_id      = tx_id;
    assign bus.tx_dlc     = tx_dlc;
    assign bus.tx_data    = tx_data;

endmodule
